seq_detector_param: RTL and testbench
=====================================

// Module: seq_detector_param
// PURPOSE
//   Parametrised Moore sequence detector, successor of the fixed "11" detector.
//   - Detects an N-bit serial pattern on input w, MSB of PATTERN first.
//   - Supports overlapping and non-overlapping match modes.
//   - Keeps a saturating count of matches.
//   - Sits in the serial-input front end; z drives downstream event logic.
// PARAMETERS
//   N        4        pattern length in bits; legal range 2..16
//   PATTERN  4'b1011  pattern to detect, N bits wide; bit N-1 is received first
//   OVERLAP  1        1: a match may reuse the tail of the previous match; 0: restart after each match
//   CNT_W    8        width of match_count
// PORTS
//   clk          in   1      system clock, rising edge
//   rst          in   1      asynchronous reset, active-high
//   en           in   1      sample enable; w is consumed only on edges where en=1
//   w            in   1      serial data input
//   z            out  1      Moore match flag; high while the FSM is in state MATCH
//   match_count  out  CNT_W  number of matches since reset; saturates, no wrap
//   state_dbg    out  5      current progress state (0..N), zero-extended
// BEHAVIOUR
//   - Reset: async assert forces state=0, z=0, match_count=0 immediately.
//     Reset may be applied at any point mid-stream; the first match after release needs N fresh bits.
//   - States: 0..N = number of pattern bits currently matched. State N is MATCH.
//   - z = (state==N). z is a function of state only (Moore); no combinational path from w to z.
//   - Transition on rising clk with en=1, from state s with input w:
//       * Form the candidate prefix P = (s matched bits), w.
//       * Take p = P, or p = w alone if s==N and OVERLAP=0.
//       * next = longest k <= N such that the first k pattern bits equal the last k bits of p.
//       * The failure function is computed at elaboration from PATTERN, not hard-coded.
//   - en=0: state, z and match_count hold.
//   - Latency: z rises in the cycle after the edge that samples the final pattern bit.
//     z stays high exactly one en-cycle per match, unless the next bit completes another match
//     (OVERLAP=1 with a self-overlapping pattern, e.g. 11 on stream 111).
//   - match_count: increments by 1 on each edge with en=1 and next==N.
//     It holds at 2^CNT_W-1 once reached.
//   - Widths: the state register is $clog2(N+1) bits. Unreachable encodings return to state 0
//     on the next edge, regardless of en.
// CONFIGURATION
//   RUNTIME_PATTERN_EN
//     Defined:
//       * Adds inputs pat_in[N-1:0] and pat_load.
//       * A pattern register, reset value PATTERN, is loaded from pat_in on an edge with pat_load=1.
//       * The same edge forces state=0 and z=0 on the next cycle; match_count is untouched.
//       * pat_load has priority over en; w on that edge is discarded.
//       * The failure function is evaluated against the pattern register.
//     Undefined: the pattern is the constant PATTERN; the ports do not exist.
// TESTING
//   1. Reset/idle: assert rst mid-cycle with state=3 -> z=0, match_count=0, state_dbg=0 immediately,
//      without waiting for a clk edge.
//   2. Basic: N=4, PATTERN=1011, OVERLAP=1, en=1, w=1,0,1,1 -> z=1 in the cycle after the 4th edge,
//      match_count=1.
//   3. Overlap: OVERLAP=1, stream 1011011 -> z pulses after bits 4 and 7, match_count=2.
//      Same stream with OVERLAP=0 -> one pulse, match_count=1.
//   4. Enable gaps: 1011 sent with en low for 3 cycles between bits -> state holds during gaps,
//      a single match, z high one en-cycle.
//   5. Saturation: CNT_W=2, send 5 matches -> match_count is 1,2,3,3,3.
//   6. RUNTIME_PATTERN_EN:
//      * From state 2, pulse pat_load with pat_in=0110 -> state 0.
//      * Then stream 0110 -> z=1 and match_count increments.
//      * Stream 1011 afterwards -> no match.

Source files
------------

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_param
// Purpose  : Moore detector for an N-bit serial pattern (MSB first) with an
//            overlapping or restarting match mode and a saturating match count.
//            Define RUNTIME_PATTERN_EN to add a loadable pattern register.
// Revision : 1.0 - initial release
// ============================================================================

module seq_detector_param #(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             w,
`ifdef RUNTIME_PATTERN_EN
  input  logic [N-1:0]     pat_in,
  input  logic             pat_load,
`endif
  output logic             z,
  output logic [CNT_W-1:0] match_count,
  output logic [4:0]       state_dbg
);

  localparam int SW = $clog2(N + 1);
  localparam int TW = 5;

  typedef logic [SW-1:0] state_t;

  localparam state_t C_MATCH = state_t'(N);

  // Longest pattern prefix that is a suffix of (first s pattern bits, b).
  function automatic logic [TW-1:0] calc_next(input logic [TW-1:0] s,
                                              input logic          b,
                                              input logic [N-1:0]  pat);
    logic [16:0] patx;
    logic [16:0] p;
    logic [16:0] mask;
    int          len;
    int          res;
    patx = 17'(pat);
    if ((int'(s) == N) && !OVERLAP) begin
      p   = 17'(b);
      len = 1;
    end else begin
      p   = ((patx >> (N - int'(s))) << 1) | 17'(b);
      len = int'(s) + 1;
    end
    res = 0;
    for (int k = 1; k <= N; k++) begin
      mask = (17'd1 << k) - 17'd1;
      if ((k <= len) && ((p & mask) == (patx >> (N - k)))) res = k;
    end
    return TW'(res);
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TW-1:0]    nxt;

`ifdef RUNTIME_PATTERN_EN
  logic [N-1:0]     pat_q, pat_d;

  always_comb begin
    nxt = calc_next(TW'(state_q), w, pat_q);
  end
`else
  function automatic logic [(N+1)*TW-1:0] build_tbl(input logic b);
    logic [(N+1)*TW-1:0] t;
    t = '0;
    for (int s = 0; s <= N; s++) t[s*TW +: TW] = calc_next(TW'(s), b, PATTERN);
    return t;
  endfunction

  localparam logic [(N+1)*TW-1:0] C_NXT0 = build_tbl(1'b0);
  localparam logic [(N+1)*TW-1:0] C_NXT1 = build_tbl(1'b1);

  always_comb begin
    nxt = '0;
    for (int s = 0; s <= N; s++) begin
      if (int'(state_q) == s) nxt = w ? C_NXT1[s*TW +: TW] : C_NXT0[s*TW +: TW];
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef RUNTIME_PATTERN_EN
    pat_d   = pat_q;
    if (pat_load) begin
      pat_d   = pat_in;
      state_d = '0;
    end else
`endif
    // Encodings above N can only come from an upset; recover without waiting for en.
    if (int'(state_q) > N) begin
      state_d = '0;
    end else if (en) begin
      state_d = state_t'(nxt);
      if ((int'(nxt) == N) && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
      cnt_q   <= '0;
`ifdef RUNTIME_PATTERN_EN
      pat_q   <= PATTERN;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef RUNTIME_PATTERN_EN
      pat_q   <= pat_d;
`endif
    end
  end

  assign z           = (state_q == C_MATCH);
  assign match_count = cnt_q;
  assign state_dbg   = 5'(state_q);

endmodule

`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// Bench for seq_detector_param: three instances (overlap/cnt8, restart/cnt8,
// overlap/cnt2) on a shared stream, checked against vectors and a reference model.

module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       w;
  logic       za, zb, zc;
  logic [7:0] ca, cb;
  logic [1:0] cc;
  logic [4:0] sa, sb, sc;
`ifdef RUNTIME_PATTERN_EN
  logic [3:0] pat_in;
  logic       pat_load;
`endif

  always #5 clk = ~clk;

  seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst), .en(en), .w(w),
`ifdef RUNTIME_PATTERN_EN
    .pat_in(pat_in), .pat_load(pat_load),
`endif
    .z(za), .match_count(ca), .state_dbg(sa));

  seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .en(en), .w(w),
`ifdef RUNTIME_PATTERN_EN
    .pat_in(pat_in), .pat_load(pat_load),
`endif
    .z(zb), .match_count(cb), .state_dbg(sb));

  seq_detector_param #(.N(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .en(en), .w(w),
`ifdef RUNTIME_PATTERN_EN
    .pat_in(pat_in), .pat_load(pat_load),
`endif
    .z(zc), .match_count(cc), .state_dbg(sc));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: a match is the last 4 sampled bits equal to the pattern,
  // with at least 4 bits seen since reset / load (and since the last match
  // when restarting).
  int         m_since [3];
  logic [3:0] m_sh    [3];
  bit         m_z     [3];
  int         m_cnt   [3];
  logic [3:0] m_pat;

  typedef struct {
    bit za, zb, zc;
    int ca, cb, cc;
  } exp_t;

  exp_t sb_q[$];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_since[k] = 0;
      m_sh[k]    = 4'b0;
      m_z[k]     = 1'b0;
      m_cnt[k]   = 0;
    end
    m_pat = 4'b1011;
    sb_q.delete();
  endtask

  task automatic model_step(input bit e, input bit wv, input bit ld, input logic [3:0] p);
    exp_t x;
    for (int k = 0; k < 3; k++) begin
      if (ld) begin
        m_since[k] = 0;
        m_z[k]     = 1'b0;
      end else if (e) begin
        m_sh[k] = {m_sh[k][2:0], wv};
        m_since[k]++;
        if (m_since[k] >= 4 && m_sh[k] == m_pat) begin
          m_z[k] = 1'b1;
          if (m_cnt[k] < ((k == 2) ? 3 : 255)) m_cnt[k]++;
          if (k == 1) m_since[k] = 0;
        end else begin
          m_z[k] = 1'b0;
        end
      end
    end
    if (ld) m_pat = p;
    x.za = m_z[0]; x.zb = m_z[1]; x.zc = m_z[2];
    x.ca = m_cnt[0]; x.cb = m_cnt[1]; x.cc = m_cnt[2];
    sb_q.push_back(x);
  endtask

  task automatic step(input bit e, input bit wv, input bit ld = 1'b0, input logic [3:0] p = 4'b0);
    exp_t x;
    en = e;
    w  = wv;
`ifdef RUNTIME_PATTERN_EN
    pat_load = ld;
    pat_in   = p;
`endif
    model_step(e, wv, ld, p);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue, expected an entry");
    end else begin
      x = sb_q.pop_front();
      chk("a_z",   32'(za), 32'(x.za));
      chk("a_cnt", 32'(ca), x.ca);
      chk("b_z",   32'(zb), 32'(x.zb));
      chk("b_cnt", 32'(cb), x.cb);
      chk("c_z",   32'(zc), 32'(x.zc));
      chk("c_cnt", 32'(cc), x.cc);
    end
`ifdef RUNTIME_PATTERN_EN
    pat_load = 1'b0;
`endif
  endtask

  typedef struct {
    bit en;
    bit w;
    bit z;
    int cnt;
    int st;
  } vec_t;

  vec_t tbl [20];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit [3:0] bits;
    bits = 4'b1011;
    // Stream 1011011 (overlap), 11, then 1011 with enable gaps, then idle zeros.
    tbl = '{
      '{1'b1, 1'b1, 1'b0, 0, 1}, '{1'b1, 1'b0, 1'b0, 0, 2},
      '{1'b1, 1'b1, 1'b0, 0, 3}, '{1'b1, 1'b1, 1'b1, 1, 4},
      '{1'b1, 1'b0, 1'b0, 1, 2}, '{1'b1, 1'b1, 1'b0, 1, 3},
      '{1'b1, 1'b1, 1'b1, 2, 4}, '{1'b1, 1'b1, 1'b0, 2, 1},
      '{1'b1, 1'b1, 1'b0, 2, 1}, '{1'b1, 1'b0, 1'b0, 2, 2},
      '{1'b0, 1'b1, 1'b0, 2, 2}, '{1'b0, 1'b0, 1'b0, 2, 2},
      '{1'b0, 1'b1, 1'b0, 2, 2}, '{1'b1, 1'b1, 1'b0, 2, 3},
      '{1'b0, 1'b0, 1'b0, 2, 3}, '{1'b1, 1'b1, 1'b1, 3, 4},
      '{1'b0, 1'b0, 1'b1, 3, 4}, '{1'b1, 1'b0, 1'b0, 3, 2},
      '{1'b1, 1'b0, 1'b0, 3, 0}, '{1'b1, 1'b0, 1'b0, 3, 0}
    };

    rst = 1'b1;
    en  = 1'b0;
    w   = 1'b0;
`ifdef RUNTIME_PATTERN_EN
    pat_in   = 4'b0;
    pat_load = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_st", 32'(sa), 0);
    chk("rst_b_st", 32'(sb), 0);
    chk("rst_c_st", 32'(sc), 0);
    chk("rst_a_z",  32'(za), 0);
    chk("rst_a_cnt", 32'(ca), 0);
    chk("rst_c_cnt", 32'(cc), 0);
    #3 rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].en, tbl[i].w);
      chk($sformatf("vec%0d_st", i),  32'(sa), tbl[i].st);
      chk($sformatf("vec%0d_z", i),   32'(za), 32'(tbl[i].z));
      chk($sformatf("vec%0d_cnt", i), 32'(ca), tbl[i].cnt);
      if (i == 6) chk("restart_cnt_1011011", 32'(cb), 1);
    end

    // 1011 with three idle en cycles between bits.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, bits[3-i]);
      chk("gap_st", 32'(sa), i + 1);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          step(1'b0, ~bits[3-i]);
          chk("gap_hold_st", 32'(sa), i + 1);
          chk("gap_hold_z",  32'(za), 0);
        end
      end
    end
    chk("gap_match_z",   32'(za), 1);
    chk("gap_match_cnt", 32'(ca), 4);
    step(1'b1, 1'b0);
    chk("gap_after_z",  32'(za), 0);
    chk("gap_after_st", 32'(sa), 2);
    step(1'b1, 1'b1);
    chk("pre_rst_st", 32'(sa), 3);

    // Asynchronous reset in the middle of a cycle, no clock edge involved.
    #3 rst = 1'b1;
    #1;
    chk("arst_st",  32'(sa), 0);
    chk("arst_z",   32'(za), 0);
    chk("arst_cnt", 32'(ca), 0);
    chk("arst_c_cnt", 32'(cc), 0);
    model_reset();
    #2 rst = 1'b0;

    // Five back-to-back matches: 2-bit counter saturates at 3.
    for (int m = 0; m < 5; m++) begin
      for (int i = 0; i < 4; i++) step(1'b1, bits[3-i]);
      chk("sat_cnt", 32'(cc), (m + 1 > 3) ? 3 : m + 1);
      chk("sat_restart_cnt", 32'(cb), m + 1);
    end

`ifdef RUNTIME_PATTERN_EN
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    chk("rt_pre_st", 32'(sa), 2);
    step(1'b1, 1'b1, 1'b1, 4'b0110);
    chk("rt_load_st",  32'(sa), 0);
    chk("rt_load_z",   32'(za), 0);
    chk("rt_load_cnt", 32'(ca), 5);
    bits = 4'b0110;
    for (int i = 0; i < 4; i++) step(1'b1, bits[3-i]);
    chk("rt_match_z",   32'(za), 1);
    chk("rt_match_cnt", 32'(ca), 6);
    bits = 4'b1011;
    for (int i = 0; i < 4; i++) step(1'b1, bits[3-i]);
    chk("rt_old_z",   32'(za), 0);
    chk("rt_old_cnt", 32'(ca), 6);
    chk("rt_old_st",  32'(sa), 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
